// File: rtl/uart_baud_tick_gen.sv
// UART receive baud/oversample tick generator with a fractional divider.
// Emits registered oversample, bit-centre and bit-end strobes; resync realigns the phase to a start-bit edge.
module uart_baud_tick_gen #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 12,
  parameter int FRAC_W     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          resync,
  input  logic [2:0]                    baud_sel,
  input  logic [DIV_W+FRAC_W-1:0]       div_custom,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          active
);

  localparam int DW   = DIV_W + FRAC_W;
  localparam int OS_W = $clog2(OVERSAMPLE);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Rounded-to-nearest Q(DIV_W.FRAC_W) system clocks per oversample tick for a given baud rate.
  function automatic logic [DW-1:0] preset_div(input logic [63:0] rate);
    logic [63:0] den;
    logic [63:0] num;
    den = rate * 64'(OVERSAMPLE);
    num = 64'(CLOCK_HZ) * (64'd1 << FRAC_W) + den / 64'd2;
    preset_div = DW'(num / den);
  endfunction

  // A period shorter than two clocks would make ticks back-to-back, so the integer part is floored at 2.
  function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
    if (d[DW-1:FRAC_W] < DIV_W'(2)) begin
      clamp_div = {DIV_W'(2), FRAC_W'(0)};
    end else begin
      clamp_div = d;
    end
  endfunction

  localparam logic [DW-1:0] D_2400   = preset_div(64'd2400);
  localparam logic [DW-1:0] D_4800   = preset_div(64'd4800);
  localparam logic [DW-1:0] D_9600   = preset_div(64'd9600);
  localparam logic [DW-1:0] D_19200  = preset_div(64'd19200);
  localparam logic [DW-1:0] D_38400  = preset_div(64'd38400);
  localparam logic [DW-1:0] D_57600  = preset_div(64'd57600);
  localparam logic [DW-1:0] D_115200 = preset_div(64'd115200);

  state_t            state_r;
  state_t            state_s;
  logic              restart_s;
  logic              tick_s;
  logic              end_s;
  logic [DW-1:0]     sel_div_s;
  logic [DW-1:0]     div_q_r;
  logic [DIV_W-1:0]  div_int_s;
  logic [FRAC_W-1:0] div_frac_s;
  logic [DIV_W:0]    period_s;
  logic [DIV_W:0]    cyc_cnt_r;
  logic [FRAC_W-1:0] frac_acc_r;
  logic              carry_r;
  logic [OS_W-1:0]   os_cnt_r;
  logic              os_tick_r;
  logic              mid_tick_r;
  logic              bit_tick_r;
  logic              active_r;

  assign div_int_s  = div_q_r[DW-1:FRAC_W];
  assign div_frac_s = div_q_r[FRAC_W-1:0];
  assign period_s   = {1'b0, div_int_s} + {{DIV_W{1'b0}}, carry_r};
  assign end_s      = (cyc_cnt_r == (period_s - {{DIV_W{1'b0}}, 1'b1}));

  // Divisor source selection from the rate selector.
  always_comb begin
    sel_div_s = D_9600;
    case (baud_sel)
      3'd0:    sel_div_s = D_2400;
      3'd1:    sel_div_s = D_4800;
      3'd2:    sel_div_s = D_9600;
      3'd3:    sel_div_s = D_19200;
      3'd4:    sel_div_s = D_38400;
      3'd5:    sel_div_s = D_57600;
      3'd6:    sel_div_s = D_115200;
      3'd7:    sel_div_s = div_custom;
      default: sel_div_s = D_9600;
    endcase
  end

  // Divisor is captured only while idle or on resync, so rate changes never disturb a bit in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q_r <= D_9600;
    end else if (!enable || resync) begin
      div_q_r <= clamp_div(sel_div_s);
    end else begin
      div_q_r <= div_q_r;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; resync beats a coincident period end, and enable low beats resync.
  always_comb begin
    state_s   = state_r;
    restart_s = 1'b0;
    tick_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s   = RUN;
          restart_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (resync) begin
          state_s   = RUN;
          restart_s = 1'b1;
        end else begin
          state_s = RUN;
          tick_s  = end_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Period, fractional and phase counters plus registered strobes.
  always_ff @(posedge clock) begin
    if (reset || (state_s == IDLE) || restart_s) begin
      cyc_cnt_r  <= '0;
      frac_acc_r <= '0;
      carry_r    <= 1'b0;
      os_cnt_r   <= '0;
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else if (tick_s) begin
      cyc_cnt_r               <= '0;
      {carry_r, frac_acc_r}   <= {1'b0, frac_acc_r} + {1'b0, div_frac_s};
      os_cnt_r                <= os_cnt_r + OS_W'(1);
      os_tick_r               <= 1'b1;
      mid_tick_r              <= (os_cnt_r == OS_W'(OVERSAMPLE / 2 - 1));
      bit_tick_r              <= (os_cnt_r == OS_W'(OVERSAMPLE - 1));
    end else begin
      cyc_cnt_r  <= cyc_cnt_r + {{DIV_W{1'b0}}, 1'b1};
      frac_acc_r <= frac_acc_r;
      carry_r    <= carry_r;
      os_cnt_r   <= os_cnt_r;
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end
  end

  // Running indicator.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_r <= 1'b0;
    end else begin
      active_r <= (state_s == RUN);
    end
  end

  assign os_tick  = os_tick_r;
  assign mid_tick = mid_tick_r;
  assign bit_tick = bit_tick_r;
  assign os_phase = os_cnt_r;
  assign active   = active_r;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed bench for uart_baud_tick_gen at 50 MHz / 16x oversample.
// Period lengths are measured in clocks from the restart edge and compared with hand-derived values.
module tb_uart_baud_tick_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        resync;
  logic [2:0]  baud_sel;
  logic [19:0] div_custom;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  os_phase;
  logic        active;

  int n_vec  = 0;
  int n_miss = 0;

  uart_baud_tick_gen #(
    .CLOCK_HZ  (50_000_000),
    .OVERSAMPLE(16),
    .DIV_W     (12),
    .FRAC_W    (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .baud_sel  (baud_sel),
    .div_custom(div_custom),
    .os_tick   (os_tick),
    .mid_tick  (mid_tick),
    .bit_tick  (bit_tick),
    .os_phase  (os_phase),
    .active    (active)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Clocks until the next os_tick, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!os_tick && n < 2000);
    if (!os_tick) chk_eq("tick_timeout", n, 0);
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    step();
    resync = 1'b0;
  endtask

  // Carry feeding the k-th period (1-based) after restart: difference of accumulated fraction overflows.
  function automatic int carry_at(input int k, input int frac);
    if (k < 2) return 0;
    return ((k - 1) * frac) / 256 - ((k - 2) * frac) / 256;
  endfunction

  initial begin
    int n;
    int cum;
    int n326;

    reset = 1'b1; enable = 1'b0; resync = 1'b0; baud_sel = 3'd2; div_custom = 20'd0;
    repeat (3) step();
    chk_eq("rst_os_tick", int'(os_tick), 0);
    chk_eq("rst_mid_tick", int'(mid_tick), 0);
    chk_eq("rst_bit_tick", int'(bit_tick), 0);
    chk_eq("rst_os_phase", int'(os_phase), 0);
    chk_eq("rst_active", int'(active), 0);

    reset = 1'b0; baud_sel = 3'd6;
    step(); step();
    chk_eq("idle_active", int'(active), 0);
    enable = 1'b1;
    step();
    chk_eq("run_active", int'(active), 1);

    // 115200: 27 x8, 28, 27 x7; mid at 216, bit at 433
    pulse_resync();
    cum = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      cum += n;
      chk_eq("b115_period", n, (k == 9) ? 28 : 27);
      chk_eq("b115_mid", int'(mid_tick), (k == 8) ? 1 : 0);
      chk_eq("b115_bit", int'(bit_tick), (k == 16) ? 1 : 0);
      chk_eq("b115_phase", int'(os_phase), k % 16);
      if (k == 8) chk_eq("b115_mid_at", cum, 216);
      if (k == 16) chk_eq("b115_bit_at", cum, 433);
    end

    // 9600 for two bits: 32*325 + floor(31*133/256)=16 carries -> 10416
    baud_sel = 3'd2;
    pulse_resync();
    cum = 0; n326 = 0;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(n);
      cum += n;
      if (n == 326) n326++;
      chk_eq("b9600_period", n, 325 + carry_at(k, 133));
    end
    chk_eq("b9600_total", cum, 10416);
    chk_eq("b9600_long_periods", n326, 16);

    // rate change mid-bit is ignored until resync
    pulse_resync();
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) baud_sel = 3'd6;
      wait_tick(n);
      chk_eq("sel_hold_period", n, 325 + carry_at(k, 133));
    end
    pulse_resync();
    wait_tick(n);
    chk_eq("sel_new_p1", n, 27);
    wait_tick(n);
    chk_eq("sel_new_p2", n, 27);

    // resync coincident with a period end suppresses that tick
    repeat (26) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk_eq("coinc_no_tick", int'(os_tick), 0);
    chk_eq("coinc_phase0", int'(os_phase), 0);
    wait_tick(n);
    chk_eq("coinc_next_period", n, 27);
    chk_eq("coinc_phase1", int'(os_phase), 1);

    // custom 0 clamps to 2 clocks; bit every 32 clocks
    baud_sel = 3'd7; div_custom = 20'd0;
    pulse_resync();
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      chk_eq("cust0_period", n, 2);
    end
    chk_eq("cust0_bit", int'(bit_tick), 1);
    cum = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      cum += n;
    end
    chk_eq("cust0_bit_spacing", cum, 32);
    chk_eq("cust0_bit2", int'(bit_tick), 1);

    // custom 5.5: 5,5,6,5,6
    div_custom = {12'd5, 8'd128};
    pulse_resync();
    for (int k = 1; k <= 5; k++) begin
      wait_tick(n);
      chk_eq("cust55_period", n, 5 + carry_at(k, 128));
    end

    // custom 1.78 clamps to 2.0
    div_custom = {12'd1, 8'd200};
    pulse_resync();
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      chk_eq("cust1_period", n, 2);
    end

    // one-cycle reset mid-bit, then 325 clocks from the release edge
    baud_sel = 3'd2;
    pulse_resync();
    wait_tick(n);
    wait_tick(n);
    repeat (50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_eq("mid_rst_os_tick", int'(os_tick), 0);
    chk_eq("mid_rst_phase", int'(os_phase), 0);
    chk_eq("mid_rst_active", int'(active), 0);
    step();
    chk_eq("post_rst_active", int'(active), 1);
    wait_tick(n);
    chk_eq("post_rst_period", n, 325);

    // enable low goes idle; resync while idle has no effect
    enable = 1'b0;
    step();
    chk_eq("dis_active", int'(active), 0);
    chk_eq("dis_phase", int'(os_phase), 0);
    pulse_resync();
    chk_eq("dis_resync_active", int'(active), 0);
    chk_eq("dis_os_tick", int'(os_tick), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
